// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipeline front end.
//   XLEN          : datapath width
//   NOP_INSTR     : canonical bubble instruction (addi x0, x0, 0)
//   fetch_state_t : fetch controller states
//   align_pc()    : clears the two low bits of an instruction address
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request on the bus
    REQ  = 2'd1,  // request outstanding
    HOLD = 2'd2   // response parked in the skid buffer
  } fetch_state_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory request/response bus of the fetch stage.
//   imem_req_o   : fetch request (fetch side drives)
//   imem_addr_o  : fetch address (fetch side drives)
//   imem_ready_i : completion strobe, qualified by imem_req_o (memory drives)
//   imem_rdata_i : instruction, valid in the completion cycle (memory drives)
// Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_unit_if;

  logic                     imem_req_o;
  logic [cpu_pkg::XLEN-1:0] imem_addr_o;
  logic                     imem_ready_i;
  logic [cpu_pkg::XLEN-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/fetch_skid.sv
// -----------------------------------------------------------------------------
// fetch_skid
// One-entry skid register holding a completed fetch {pc, pc4, instr} while the
// pipeline is stalled. Load has priority over clear.
//   clk, rst_n        : clock, async active-low reset
//   load_i            : capture pc_i/pc4_i/instr_i and mark the entry valid
//   clear_i           : drop the entry
//   pc_i, pc4_i       : address of the parked fetch and its successor
//   instr_i           : parked instruction word
//   valid_o           : entry holds a parked fetch
//   pc_o, pc4_o, instr_o : parked contents
// -----------------------------------------------------------------------------
module fetch_skid
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc4_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic [XLEN-1:0] instr_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc4_q;
  logic [XLEN-1:0] instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      // NOTE: the payload is a single register entry, not a RAM, so it is
      // reset along with the valid bit; this keeps unknowns off the outputs.
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      pc4_q   <= pc4_i;
      instr_q <= instr_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the PC, issues instruction-memory requests,
// computes PC+4 and loads the IF/ID pipeline register. A one-entry skid buffer
// parks a fetch that completes while the pipeline is stalled.
//   RESET_PC          : PC loaded at reset
//   clk, rst_n        : clock, async active-low reset
//   stall_i           : hold IF/ID and PC
//   flush_i           : replace IF/ID contents with a bubble
//   redirect_i        : one-cycle taken branch/jump pulse
//   redirect_pc_i     : redirect target (low two bits ignored)
//   imem              : instruction-memory bus (fetch_unit_if.master)
//   if_id_valid_o     : IF/ID holds a real instruction
//   if_id_pc_o        : PC of the IF/ID instruction
//   if_id_pc4_o       : that PC + 4
//   if_id_instr_o     : IF/ID instruction, NOP when not valid
//   perf_bubbles_o    : saturating count of bubble loads into IF/ID
//                       (only when FETCH_PERF_CNT_EN is defined)
// -----------------------------------------------------------------------------
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  fetch_unit_if.master     imem,
  output logic             if_id_valid_o,
  output logic [XLEN-1:0]  if_id_pc_o,
  output logic [XLEN-1:0]  if_id_pc4_o,
  output logic [XLEN-1:0]  if_id_instr_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_bubbles_o
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;   // bus address; lags pc_q while a killed fetch drains
  logic            kill_q, kill_d;   // outstanding response must be discarded
  logic            req_q;

  logic            if_id_valid_q;
  logic [XLEN-1:0] if_id_pc_q;
  logic [XLEN-1:0] if_id_pc4_q;
  logic [XLEN-1:0] if_id_instr_q;

  logic            fire;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;
  logic            deliver;
  logic [XLEN-1:0] dlv_pc, dlv_pc4, dlv_instr;
  logic            skid_load, skid_clear;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc, skid_pc4, skid_instr;

  assign fire     = req_q & imem.imem_ready_i;
  assign target   = align_pc(redirect_pc_i);
  assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32

  fetch_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (pc_q),
    .pc4_i   (pc_plus4),
    .instr_i (imem.imem_rdata_i),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .pc4_o   (skid_pc4),
    .instr_o (skid_instr)
  );

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    deliver    = 1'b0;
    dlv_pc     = pc_q;
    dlv_pc4    = pc_plus4;
    dlv_instr  = imem.imem_rdata_i;

    unique case (state_q)
      IDLE: begin
        if (redirect_i) pc_d = target;
        if (!stall_i)   state_d = REQ;
      end

      REQ: begin
        if (!fire) begin
          // Retarget now; the bus keeps the old address until it completes.
          if (redirect_i) begin
            kill_d = 1'b1;
            pc_d   = target;
          end
        end else if (kill_q || redirect_i) begin
          kill_d = 1'b0;
          if (redirect_i) pc_d = target;
          state_d = stall_i ? IDLE : REQ;
        end else if (!stall_i) begin
          deliver = 1'b1;
          pc_d    = pc_plus4;
        end else begin
          skid_load = 1'b1;
          pc_d      = pc_plus4;
          state_d   = HOLD;
        end
      end

      HOLD: begin
        if (redirect_i) begin
          skid_clear = 1'b1;
          pc_d       = target;
          state_d    = stall_i ? IDLE : REQ;
        end else if (!stall_i) begin
          deliver    = skid_valid;
          dlv_pc     = skid_pc;
          dlv_pc4    = skid_pc4;
          dlv_instr  = skid_instr;
          skid_clear = 1'b1;
          state_d    = REQ;
        end
      end

      default: state_d = IDLE;
    endcase

    // Address is frozen while a request is outstanding, otherwise it follows PC.
    addr_d = (state_q == REQ && !fire) ? addr_q : pc_d;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q;
  logic        bubble;
  assign bubble = !flush_i && !stall_i && !deliver;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      addr_q        <= RESET_PC;
      kill_q        <= 1'b0;
      req_q         <= 1'b0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_pc4_q   <= '0;
      if_id_instr_q <= NOP_INSTR;
`ifdef FETCH_PERF_CNT_EN
      perf_q        <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
      req_q   <= (state_d == REQ);

      if (flush_i) begin
        if_id_valid_q <= 1'b0;
        if_id_instr_q <= NOP_INSTR;
      end else if (stall_i) begin
        // hold IF/ID
      end else if (deliver) begin
        if_id_valid_q <= 1'b1;
        if_id_pc_q    <= dlv_pc;
        if_id_pc4_q   <= dlv_pc4;
        if_id_instr_q <= dlv_instr;
      end else begin
        if_id_valid_q <= 1'b0;
        if_id_instr_q <= NOP_INSTR;
      end

`ifdef FETCH_PERF_CNT_EN
      if (bubble && perf_q != 32'hFFFF_FFFF) perf_q <= perf_q + 32'd1;
`endif
    end
  end

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = addr_q;
  assign if_id_valid_o    = if_id_valid_q;
  assign if_id_pc_o       = if_id_pc_q;
  assign if_id_pc4_o      = if_id_pc4_q;
  assign if_id_instr_o    = if_id_instr_q;
`ifdef FETCH_PERF_CNT_EN
  assign perf_bubbles_o   = perf_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Expected IF/ID deliveries are queued as the
// stimulus is issued; a monitor compares each new IF/ID instruction against
// the queue head. Bus address/request and IF/ID state are checked directly.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import cpu_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o, if_id_pc4_o, if_id_instr_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bubbles_o;
  logic [31:0] perf_base;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  logic stall_at_edge = 1'b0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (bus),
    .if_id_valid_o (if_id_valid_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_pc4_o   (if_id_pc4_o),
    .if_id_instr_o (if_id_instr_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_bubbles_o(perf_bubbles_o)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents: a recognisable word derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign bus.imem_rdata_i = mem_word(bus.imem_addr_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] pc4);
    exp_t e;
    e.pc    = pc;
    e.pc4   = pc4;
    e.instr = mem_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Stall seen by the DUT at the last rising edge; a held IF/ID is not new.
  always @(posedge clk) stall_at_edge <= stall_i;

  // Monitor: every newly loaded IF/ID instruction must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if_id_valid_o === 1'b1 && !stall_at_edge) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_delivery actual_pc=%08h expected=none at %0t", if_id_pc_o, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pc",    if_id_pc_o,    e.pc);
        check("sb_pc4",   if_id_pc4_o,   e.pc4);
        check("sb_instr", if_id_instr_o, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    stall_i          = 1'b0;
    flush_i          = 1'b0;
    redirect_i       = 1'b0;
    redirect_pc_i    = '0;
    bus.imem_ready_i = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_req",   {31'b0, bus.imem_req_o}, 32'h0);
    check("rst_addr",  bus.imem_addr_o,         32'h0000_0100);
    check("rst_valid", {31'b0, if_id_valid_o},  32'h0);
    check("rst_pc",    if_id_pc_o,              32'h0);
    check("rst_pc4",   if_id_pc4_o,             32'h0);
    check("rst_instr", if_id_instr_o,           NOP_INSTR);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf",  perf_bubbles_o,          32'h0);
`endif

    // Back-to-back fetch from 0x100, then two wait states on 0x104
    rst_n = 1'b1;
    bus.imem_ready_i = 1'b1;
    push_exp(32'h0000_0100, 32'h0000_0104);
    push_exp(32'h0000_0104, 32'h0000_0108);
    tick();
    check("c1_req",  {31'b0, bus.imem_req_o}, 32'h1);
    check("c1_addr", bus.imem_addr_o,         32'h0000_0100);
    tick();
    check("c2_addr", bus.imem_addr_o,         32'h0000_0104);
    bus.imem_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("ws_addr",  bus.imem_addr_o,        32'h0000_0104);
      check("ws_valid", {31'b0, if_id_valid_o}, 32'h0);
    end
    bus.imem_ready_i = 1'b1;
    tick();
    check("c5_addr", bus.imem_addr_o, 32'h0000_0108);

    // Redirect to 0x2000 while the 0x108 fetch is outstanding
    bus.imem_ready_i = 1'b0;
    redirect_i       = 1'b1;
    flush_i          = 1'b1;
    redirect_pc_i    = 32'h0000_2000;
    tick();
    check("rd_addr_hold", bus.imem_addr_o,         32'h0000_0108);
    check("rd_req",       {31'b0, bus.imem_req_o}, 32'h1);
    redirect_i = 1'b0;
    flush_i    = 1'b0;
    tick();
    check("rd_addr_hold2", bus.imem_addr_o, 32'h0000_0108);
    bus.imem_ready_i = 1'b1;
    push_exp(32'h0000_2000, 32'h0000_2004);
    tick();
    check("rd_target_addr", bus.imem_addr_o,        32'h0000_2000);
    check("rd_killed",      {31'b0, if_id_valid_o}, 32'h0);
    tick();
    check("rd_next_addr", bus.imem_addr_o, 32'h0000_2004);

    // Stall for three cycles while the 0x2004 fetch completes
    stall_i = 1'b1;
    push_exp(32'h0000_2004, 32'h0000_2008);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_req",   {31'b0, bus.imem_req_o}, 32'h0);
      check("st_valid", {31'b0, if_id_valid_o},  32'h1);
      check("st_pc",    if_id_pc_o,              32'h0000_2000);
    end
    stall_i = 1'b0;
    tick();
    check("st_rel_req",  {31'b0, bus.imem_req_o}, 32'h1);
    check("st_rel_addr", bus.imem_addr_o,         32'h0000_2008);
    push_exp(32'h0000_2008, 32'h0000_200C);

    // Redirect to 0xFFFF_FFFC in the completion cycle of 0x200C; then wrap
    tick();
    redirect_i    = 1'b1;
    flush_i       = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    push_exp(32'hFFFF_FFFC, 32'h0000_0000);
    tick();
    check("wr_addr",  bus.imem_addr_o,        32'hFFFF_FFFC);
    check("wr_valid", {31'b0, if_id_valid_o}, 32'h0);
    redirect_i = 1'b0;
    flush_i    = 1'b0;
    tick();
    check("wr_next_addr", bus.imem_addr_o, 32'h0000_0000);

    // Misaligned redirect target 0x1003 while 0x0 is outstanding
    bus.imem_ready_i = 1'b0;
    redirect_i       = 1'b1;
    flush_i          = 1'b1;
    redirect_pc_i    = 32'h0000_1003;
    tick();
    check("al_addr_hold", bus.imem_addr_o, 32'h0000_0000);
    redirect_i       = 1'b0;
    flush_i          = 1'b0;
    bus.imem_ready_i = 1'b1;
    tick();
    check("al_addr", bus.imem_addr_o, 32'h0000_1000);

    // Flush and stall together while 0x1000 completes: parked, IF/ID bubbled
`ifdef FETCH_PERF_CNT_EN
    perf_base = perf_bubbles_o;
`endif
    stall_i = 1'b1;
    flush_i = 1'b1;
    push_exp(32'h0000_1000, 32'h0000_1004);
    tick();
    check("fs_valid", {31'b0, if_id_valid_o},  32'h0);
    check("fs_instr", if_id_instr_o,           NOP_INSTR);
    check("fs_req",   {31'b0, bus.imem_req_o}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("fs_perf",  perf_bubbles_o,          perf_base);
`endif
    stall_i = 1'b0;
    flush_i = 1'b0;
    tick();
    check("fs_rel_req",  {31'b0, bus.imem_req_o}, 32'h1);
    check("fs_rel_addr", bus.imem_addr_o,         32'h0000_1004);
    bus.imem_ready_i = 1'b0;
    tick();
    check("idle_valid", {31'b0, if_id_valid_o}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("bubble_perf", perf_bubbles_o, perf_base + 32'd1);
`endif

    tick(); tick();
    check("sb_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
